// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the boot-time program loader.
// Holds the loader state encoding, the default frame header byte and the
// frame field widths used by prog_loader and word_assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  localparam int unsigned BYTE_W = 8;   // stream byte width
  localparam int unsigned LEN_W  = 16;  // word-count field width
  localparam int unsigned WORD_W = 32;  // instruction word width
  localparam int unsigned CHK_W  = 8;   // checksum width

endpackage

// File: rtl/word_assembler.sv
// word_assembler: collects bytes into a 32-bit little-endian word.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   clear        - synchronous clear of the byte counter and word
//   byte_valid   - byte_data is consumed this cycle
//   byte_data    - incoming byte
//   word         - assembled word (first byte in bits [7:0])
//   word_valid   - one-cycle pulse in the cycle after the 4th byte
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && (byte_cnt == 2'd3);
      if (byte_valid) begin
        // Shift right so that after four bytes the first one sits in the LSBs.
        word     <= {byte_data, word[WORD_W-1:BYTE_W]};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time instruction-memory loader fed by a byte stream.
// Frame: HEADER, LEN_LO, LEN_HI, N*4 little-endian data bytes, CHK (XOR of
// data bytes). The core is held in reset until a verified image is written.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   rx_data, rx_valid   - incoming byte stream
//   rx_ready            - byte accepted when rx_valid && rx_ready
//   mem_we              - one-cycle instruction-memory write strobe
//   mem_addr, mem_wdata - word address / data for the write
//   cpu_reset           - reset for the processor core
//   done, error         - status of the last load
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  HEADER = DEFAULT_HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [BYTE_W-1:0] len_lo;
  logic [CHK_W-1:0]  chk;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   last_idx;

  logic              accept;
  logic [LEN_W-1:0]  len_full;
  logic              len_bad;
  logic              asm_clear;
  logic              asm_in_valid;
  logic [WORD_W-1:0] asm_word;
  logic              asm_word_valid;

  assign accept   = rx_valid && rx_ready;
  assign len_full = {rx_data, len_lo};
  assign len_bad  = (len_full == '0) ||
                    ({1'b0, len_full} > ((LEN_W+1)'(1) << ADDR_W));

  assign asm_clear    = accept && (state == ST_LEN_HI) && !len_bad;
  assign asm_in_valid = accept && (state == ST_DATA);

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_in_valid),
    .byte_data  (rx_data),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  // The assembler's registered pulse is the write slot; the word register
  // cannot shift during it because no byte is accepted then.
  assign mem_we    = asm_word_valid;
  assign mem_wdata = asm_word;
  assign mem_addr  = word_cnt[ADDR_W-1:0];
  assign rx_ready  = !asm_word_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_lo    <= '0;
      chk       <= '0;
      word_cnt  <= '0;
      last_idx  <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (rx_data == HEADER)) state <= ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_lo <= rx_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            if (len_bad) begin
              error <= 1'b1;
              state <= ST_ERR;
            end else begin
              last_idx <= (ADDR_W+1)'(len_full - LEN_W'(1));
              word_cnt <= '0;
              chk      <= '0;
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) chk <= chk ^ rx_data;
          if (asm_word_valid) begin
            word_cnt <= word_cnt + (ADDR_W+1)'(1);
            if (word_cnt == last_idx) state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (accept) begin
            if (rx_data == chk) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              state     <= ST_DONE;
            end else begin
              error <= 1'b1;
              state <= ST_ERR;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (accept && (rx_data == HEADER)) begin
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            state     <= ST_LEN_LO;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits beside the `procesador` top level and writes instruction memory from a byte stream, normally fed by a UART receiver. It holds the core in reset while loading and releases it only after a complete, checksum-verified image has been written. Testbenches and hardware therefore get the same path for loading a program before execution starts.

## Interface
- `ADDR_W`, default 8: word-address width of the instruction memory. The maximum image size is 2^ADDR_W words.
- `HEADER`, default 8'hA5: frame start byte.

- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid. A byte transfers when `rx_valid && rx_ready`.
- `rx_ready` out 1: loader can accept a byte.
- `mem_we` out 1: one-cycle instruction-memory write strobe.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: word to write.
- `cpu_reset` out 1: drives the `reset` input of `procesador`.
- `done` out 1: last load completed and its checksum matched.
- `error` out 1: last load was aborted or its checksum failed.

## Operation
- Frame format, in byte order:
  - `HEADER`
  - `LEN_LO`, `LEN_HI`: N, a 16-bit word count.
  - N×4 data bytes, each word little-endian.
  - `CHK`: XOR of all data bytes.
- States:
  - IDLE: waits for `HEADER`. Any other byte is consumed and ignored, and the state does not change.
  - LEN_LO → LEN_HI: capture N.
    - N == 0 or N > 2^ADDR_W → ERR.
    - Otherwise → DATA, clear the word counter and the checksum.
  - DATA: shift bytes into the assembler and XOR each one into the checksum.
    - On the 4th byte, assert `mem_we` for one cycle on the next cycle, with `mem_addr` = word index (starting at 0).
    - After word N−1 is written → CHK.
  - CHK: compare the received byte with the running XOR.
    - Equal → DONE.
    - Not equal → ERR.
  - DONE: `done`=1, `cpu_reset`=0.
  - ERR: `error`=1, `cpu_reset`=1.
- Restart: in DONE or ERR, an accepted `HEADER` byte does all of the following and moves to LEN_LO:
  - sets `cpu_reset`=1;
  - clears `done` and `error`.
- In DONE or ERR, non-header bytes are ignored.
- `rx_ready`=1 in every state except the cycle in which `mem_we`=1 (the write slot).
- Width rules:
  - Word index counter is ADDR_W+1 bits.
  - Checksum is 8 bits.
  - N is compared as 17-bit unsigned against 2^ADDR_W.
- Words written before a checksum failure stay in memory. The core is not released.

## Timing
- Reset values:
  - `rx_ready`=1, `cpu_reset`=1;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `done`=0, `error`=0;
  - state = IDLE.
- Write latency: `mem_we` is high exactly one cycle after the cycle that accepts a word's 4th byte. `mem_addr` and `mem_wdata` are stable in that cycle.
- Release latency: `cpu_reset` falls and `done` rises one cycle after `CHK` is accepted.
- Restart latency: `cpu_reset` rises one cycle after a restart `HEADER` is accepted.
- `rx_valid` may be held continuously. A byte offered during the write slot is taken the following cycle, and no byte is lost.
- `reset` mid-frame: all outputs go to their reset values immediately and any partial word is discarded. The next frame must start from `HEADER`.
- Gaps (`rx_valid`=0) of any length between bytes are legal; there is no timeout.

## Structure
- Shared package `loader_pkg`:
  - state encoding: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR;
  - default `HEADER` constant;
  - frame field widths.
- Sub-module `word_assembler`:
  - byte-in to 32-bit little-endian word-out;
  - 2-bit byte counter;
  - `word_valid` pulse;
  - synchronous `clear`.
- The top level holds the FSM, word counter, checksum, and output registers.

## Test plan
- Reset, then frame A5 01 00 13 00 00 00 13 → one write: `mem_addr`=0, `mem_wdata`=32'h00000013. `done`=1 and `cpu_reset`=0 one cycle after the checksum byte.
- Two-word frame with data 0x00500093, 0x00A00113 and a correct checksum, `rx_valid` held high throughout → writes at `mem_addr` 0 and 1. `rx_ready` drops only in the two write cycles, and no byte is dropped.
- Same frame with checksum XOR 8'h01 → both words written, `error`=1, `done`=0, `cpu_reset` stays 1.
- Length 0x0000, then a separate frame with length 0x0101 at `ADDR_W`=8 → each gives `error`=1 right after `LEN_HI`, with no `mem_we`.
- Garbage bytes 00 FF 5A before A5 → ignored, and the following frame loads correctly. A restart A5 sent after DONE raises `cpu_reset` the next cycle and clears `done`.
- `reset` asserted after 2 data bytes of word 0 → immediate reset values. A full valid frame sent afterwards writes `mem_addr`=0 with its own data, with no leftover bytes from the aborted frame.
